lsu_mem_bridge: RTL and testbench
=================================

Name: lsu_mem_bridge

Overview:
Load/store bridge between the CPU core's data port and a handshaked data-memory/bus port with variable latency.
- Accepts one RV32I load or store per request.
- Generates byte-lane strobes and little-endian aligned write data.
- Waits for memory grant and read data, then returns sign/zero-extended load data to the core.
- Sits directly downstream of the core's data_read/data_write/data_addr/data_in outputs and replaces a fixed-latency memory hookup.

Parameters:
TIMEOUT, 16, max cycles in WAIT without mem_rvalid before an error response (>=2)
CNT_W, 5, width of the timeout counter; must hold TIMEOUT

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
cpu_req_valid  input  1  core presents a request
cpu_req_ready  output  1  bridge can accept (IDLE only)
cpu_we  input  1  1=store, 0=load
cpu_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
cpu_addr  input  32  byte address
cpu_wdata  input  32  store data in rs2 layout (LSBs valid)
cpu_resp_valid  output  1  one-cycle completion pulse
cpu_rdata  output  32  extended load data; 0 for stores/errors
cpu_err  output  1  valid with cpu_resp_valid: misaligned, illegal funct3, or timeout
mem_req  output  1  memory request, held until mem_gnt
mem_we  output  4  byte write strobes; 0000 = read
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wdata  output  32  lane-aligned store data
mem_gnt  input  1  memory accepts the request this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read word

Behaviour:
- Reset: state=IDLE. cpu_req_ready=1; cpu_resp_valid, cpu_err, mem_req=0; mem_we=0; cpu_rdata, mem_addr, mem_wdata=0; timeout counter=0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Handshake fires on cpu_req_valid & cpu_req_ready.
  - Latch we, funct3, addr, wdata.
  - Illegal funct3 (011, 110, 111; store with 100/101) -> RESP with err=1, no memory access.
  - Misaligned access (H with addr[0]=1, W with addr[1:0]!=0) -> RESP with err=1, no memory access.
  - Otherwise -> ISSUE.
- ISSUE:
  - mem_req=1; mem_we, mem_addr, mem_wdata registered and stable until gnt.
  - Store strobes: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111.
  - Store data: byte replicated x4; half replicated x2; word as-is.
  - On mem_gnt: store -> RESP (err=0); load -> WAIT, counter cleared.
  - If mem_rvalid arrives in the same cycle as gnt, capture the data and go straight to RESP.
- WAIT:
  - Counter increments each cycle.
  - mem_rvalid: select byte/half by addr[1:0], sign-extend (B/H) or zero-extend (BU/HU), then -> RESP.
  - Counter reaches TIMEOUT-1 with no rvalid: -> RESP with err=1, rdata=0.
- RESP:
  - cpu_resp_valid=1 for exactly one cycle with cpu_rdata/cpu_err, then -> IDLE.
  - cpu_rdata/cpu_err hold their values until the next response.
- Latency: store = 1 (accept) + gnt wait + 1. Load = accept + gnt + data wait + 1. Minimum 3 cycles from handshake to resp_valid.
- mem_rvalid/mem_gnt outside ISSUE/WAIT are ignored.
- A reset mid-operation forces IDLE in the same edge and drops mem_req immediately. An outstanding memory response is discarded.
- cpu_req_valid while not ready is ignored; the core must hold the request.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined: misaligned H/W accesses produce an err response without a memory access (as above).
- Undefined: no alignment check. The address is force-aligned (H clears addr[0], W clears addr[1:0]) and the access proceeds normally. cpu_err is asserted only for illegal funct3 or timeout.

Decomposition:
- Shared package lsu_pkg holds:
  - state encoding constants;
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - a function computing strobes from funct3+addr[1:0].
- One sub-module, lsu_load_align: combinational extract and extend from rdata, addr[1:0], funct3. Kept separate so it can be unit-tested independently.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, gnt after 2 cycles -> mem_we=1111, mem_addr=0x100, mem_wdata=0xDEADBEEF, resp_valid 1 cycle after gnt, err=0.
- SB addr 0x103 data 0x000000A5 -> mem_we=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr 0x102, mem_rdata=0x12801234 rvalid 3 cycles after gnt -> cpu_rdata=0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00001280.
- LW addr 0x101 with macro -> err=1, mem_req never asserted. Without macro -> mem_addr=0x100, normal load.
- Load granted, no rvalid for TIMEOUT=16 cycles -> resp_valid with err=1, rdata=0; late rvalid afterwards ignored.
- rst asserted while in WAIT -> next cycle IDLE, mem_req=0, cpu_req_ready=1, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bridge: FSM state encoding,
// RV32I load/store funct3 codes and the byte-strobe helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-lane write strobes for a store of the given size at the given lane.
    function automatic logic [3:0] lsu_strobe(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
        logic [3:0] strb;
        strb = 4'b0000;
        case (funct3)
            F3_B:    strb = 4'b0001 << addr_lo;
            F3_H:    strb = 4'b0011 << {addr_lo[1], 1'b0};
            F3_W:    strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half/word from a memory read word and
// sign- or zero-extends it according to the RV32I load funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by extension; unknown codes return zero.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        data     = 32'h0000_0000;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h000000, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0000, half_sel};
            F3_W:    data = rdata;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// Load/store bridge from the core data port to a handshaked, variable
// latency memory port. Build option LSU_MISALIGN_CHECK_EN: when defined,
// misaligned halfword/word accesses complete with an error and never reach
// memory; when undefined they are force-aligned and proceed normally.
module lsu_mem_bridge
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req_valid,
    output logic        cpu_req_ready,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_funct3,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_resp_valid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        mem_req,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [3:0]  mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic        cpu_err_q, cpu_err_d;

    logic        is_half, is_word, legal_f3, req_err;
    logic [1:0]  eff_lo;
    logic [31:0] store_data;
    logic [31:0] load_data;

    lsu_load_align u_align (
        .rdata   (mem_rdata),
        .addr_lo (addr_lo_q),
        .funct3  (funct3_q),
        .data    (load_data)
    );

    // Decode the incoming request: legality, alignment and lane-replicated store data.
    always_comb begin
        is_half  = (cpu_funct3 == F3_H) || (cpu_funct3 == F3_HU);
        is_word  = (cpu_funct3 == F3_W);
        legal_f3 = (cpu_funct3 == F3_B) || (cpu_funct3 == F3_H) || (cpu_funct3 == F3_W) ||
                   (!cpu_we && ((cpu_funct3 == F3_BU) || (cpu_funct3 == F3_HU)));
        eff_lo   = is_word ? 2'b00 : (is_half ? {cpu_addr[1], 1'b0} : cpu_addr[1:0]);
`ifdef LSU_MISALIGN_CHECK_EN
        req_err  = !legal_f3 || (is_half && cpu_addr[0]) || (is_word && (cpu_addr[1:0] != 2'b00));
`else
        req_err  = !legal_f3;
`endif
        case (cpu_funct3)
            F3_B:    store_data = {4{cpu_wdata[7:0]}};
            F3_H:    store_data = {2{cpu_wdata[15:0]}};
            default: store_data = cpu_wdata;
        endcase
    end

    // Next-state and registered-output logic for the request/response FSM.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_err_d   = cpu_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_valid) begin
                    we_d      = cpu_we;
                    funct3_d  = cpu_funct3;
                    addr_lo_d = eff_lo;
                    if (req_err) begin
                        cpu_err_d   = 1'b1;
                        cpu_rdata_d = 32'h0000_0000;
                        state_d     = ST_RESP;
                    end else begin
                        mem_we_d    = cpu_we ? lsu_strobe(cpu_funct3, eff_lo) : 4'b0000;
                        mem_addr_d  = {cpu_addr[31:2], 2'b00};
                        mem_wdata_d = cpu_we ? store_data : 32'h0000_0000;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        cpu_err_d   = 1'b0;
                        cpu_rdata_d = 32'h0000_0000;
                        state_d     = ST_RESP;
                    end else if (mem_rvalid) begin
                        cpu_err_d   = 1'b0;
                        cpu_rdata_d = load_data;
                        state_d     = ST_RESP;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    cpu_err_d   = 1'b0;
                    cpu_rdata_d = load_data;
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    cpu_err_d   = 1'b1;
                    cpu_rdata_d = 32'h0000_0000;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            cnt_q       <= '0;
            cpu_rdata_q <= 32'h0000_0000;
            cpu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_err_q   <= cpu_err_d;
        end
    end

    assign cpu_req_ready  = (state_q == ST_IDLE);
    assign cpu_resp_valid = (state_q == ST_RESP);
    assign cpu_rdata      = cpu_rdata_q;
    assign cpu_err        = cpu_err_q;
    assign mem_req        = (state_q == ST_ISSUE);
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed testbench for lsu_mem_bridge: stores, sign/zero-extended loads,
// illegal and misaligned requests, timeout and mid-operation reset.
module tb_lsu_mem_bridge;

    logic        clk;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        mem_req;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    lsu_mem_bridge #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_we         (cpu_we),
        .cpu_funct3     (cpu_funct3),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_rdata      (cpu_rdata),
        .cpu_err        (cpu_err),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock edge and settle; both driving and sampling happen here.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for a single handshake edge (bridge is idle).
    task automatic apply_stimulus(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req_valid = 1'b1;
        cpu_we        = we;
        cpu_funct3    = f3;
        cpu_addr      = addr;
        cpu_wdata     = wdata;
        tick();
        cpu_req_valid = 1'b0;
    endtask

    // Load with grant now and read data two WAIT cycles later; checks the response.
    task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] word, input logic [31:0] exp);
        apply_stimulus(1'b0, f3, addr, 32'h0);
        check_output({tag, "_we"}, {28'h0, mem_we}, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick(2);
        check_output({tag, "_wait_novalid"}, {31'h0, cpu_resp_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        tick();
        mem_rvalid = 1'b0;
        check_output({tag, "_valid"}, {31'h0, cpu_resp_valid}, 32'h1);
        check_output({tag, "_rdata"}, cpu_rdata, exp);
        check_output({tag, "_err"}, {31'h0, cpu_err}, 32'h0);
        tick();
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_we = 1'b0;
        cpu_funct3 = 3'b000;
        cpu_addr = 32'h0;
        cpu_wdata = 32'h0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        tick(2);
        rst = 1'b0;

        // Reset state
        check_output("rst_ready", {31'h0, cpu_req_ready}, 32'h1);
        check_output("rst_resp", {31'h0, cpu_resp_valid}, 32'h0);
        check_output("rst_err", {31'h0, cpu_err}, 32'h0);
        check_output("rst_req", {31'h0, mem_req}, 32'h0);
        check_output("rst_we", {28'h0, mem_we}, 32'h0);
        check_output("rst_rdata", cpu_rdata, 32'h0);
        check_output("rst_addr", mem_addr, 32'h0);
        check_output("rst_wdata", mem_wdata, 32'h0);

        // SW 0x100, grant after two cycles
        apply_stimulus(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        check_output("sw_req", {31'h0, mem_req}, 32'h1);
        check_output("sw_ready", {31'h0, cpu_req_ready}, 32'h0);
        check_output("sw_we", {28'h0, mem_we}, 32'hF);
        check_output("sw_addr", mem_addr, 32'h100);
        check_output("sw_wdata", mem_wdata, 32'hDEADBEEF);
        tick(2);
        check_output("sw_req_held", {31'h0, mem_req}, 32'h1);
        check_output("sw_wdata_held", mem_wdata, 32'hDEADBEEF);
        check_output("sw_noresp", {31'h0, cpu_resp_valid}, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_output("sw_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check_output("sw_err", {31'h0, cpu_err}, 32'h0);
        check_output("sw_req_drop", {31'h0, mem_req}, 32'h0);
        tick();
        check_output("sw_resp_pulse", {31'h0, cpu_resp_valid}, 32'h0);
        check_output("sw_ready_back", {31'h0, cpu_req_ready}, 32'h1);

        // SB 0x103, immediate grant
        apply_stimulus(1'b1, 3'b000, 32'h103, 32'h000000A5);
        check_output("sb_we", {28'h0, mem_we}, 32'h8);
        check_output("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        check_output("sb_addr", mem_addr, 32'h100);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        check_output("sb_resp", {31'h0, cpu_resp_valid}, 32'h1);
        tick();

        // SH 0x102
        apply_stimulus(1'b1, 3'b001, 32'h102, 32'h1234ABCD);
        check_output("sh_we", {28'h0, mem_we}, 32'hC);
        check_output("sh_wdata", mem_wdata, 32'hABCDABCD);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();

        // Loads with extension
        load_check("lb", 3'b000, 32'h102, 32'h12801234, 32'hFFFFFF80);
        load_check("lbu", 3'b100, 32'h102, 32'h12801234, 32'h00000080);
        load_check("lhu", 3'b101, 32'h102, 32'h12801234, 32'h00001280);
        load_check("lh", 3'b001, 32'h100, 32'h0000F00D, 32'hFFFFF00D);
        load_check("lw", 3'b010, 32'h104, 32'h89ABCDEF, 32'h89ABCDEF);

        // Grant and read data in the same cycle
        apply_stimulus(1'b0, 3'b100, 32'h101, 32'h0);
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'h0000FF00;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        check_output("same_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check_output("same_rdata", cpu_rdata, 32'h000000FF);
        tick();

        // Illegal funct3: load 011 and store 100
        apply_stimulus(1'b0, 3'b011, 32'h100, 32'h0);
        check_output("ill_ld_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check_output("ill_ld_err", {31'h0, cpu_err}, 32'h1);
        check_output("ill_ld_req", {31'h0, mem_req}, 32'h0);
        check_output("ill_ld_rdata", cpu_rdata, 32'h0);
        tick();
        apply_stimulus(1'b1, 3'b100, 32'h100, 32'h55);
        check_output("ill_st_err", {31'h0, cpu_err}, 32'h1);
        check_output("ill_st_req", {31'h0, mem_req}, 32'h0);
        tick();
        check_output("err_hold", {31'h0, cpu_err}, 32'h1);

        // Misaligned LW 0x101
        apply_stimulus(1'b0, 3'b010, 32'h101, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
        check_output("mis_req", {31'h0, mem_req}, 32'h0);
        check_output("mis_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check_output("mis_err", {31'h0, cpu_err}, 32'h1);
        tick();
`else
        check_output("mis_req", {31'h0, mem_req}, 32'h1);
        check_output("mis_addr", mem_addr, 32'h100);
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        check_output("mis_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check_output("mis_err", {31'h0, cpu_err}, 32'h0);
        check_output("mis_rdata", cpu_rdata, 32'hCAFEF00D);
        tick();
`endif

        // Timeout: granted load never gets read data
        apply_stimulus(1'b0, 3'b010, 32'h200, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick(15);
        check_output("to_early", {31'h0, cpu_resp_valid}, 32'h0);
        tick();
        check_output("to_resp", {31'h0, cpu_resp_valid}, 32'h1);
        check_output("to_err", {31'h0, cpu_err}, 32'h1);
        check_output("to_rdata", cpu_rdata, 32'h0);
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 32'h11111111;
        tick();
        mem_rvalid = 1'b0;
        check_output("to_late_resp", {31'h0, cpu_resp_valid}, 32'h0);
        check_output("to_late_rdata", cpu_rdata, 32'h0);
        check_output("to_late_ready", {31'h0, cpu_req_ready}, 32'h1);

        // Reset while waiting for read data
        apply_stimulus(1'b0, 3'b010, 32'h300, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_output("mrst_req", {31'h0, mem_req}, 32'h0);
        check_output("mrst_ready", {31'h0, cpu_req_ready}, 32'h1);
        check_output("mrst_resp", {31'h0, cpu_resp_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata = 32'h22222222;
        tick();
        mem_rvalid = 1'b0;
        check_output("mrst_discard", {31'h0, cpu_resp_valid}, 32'h0);
        check_output("mrst_rdata", cpu_rdata, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
